// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and types for the memory-mapped seven-segment controller
package sevenseg_pkg;

  localparam logic [2:0]  OFS_DATA  = 3'h0;
  localparam logic [2:0]  OFS_CTRL  = 3'h4;
  localparam logic [31:0] CTRL_RST  = 32'h0000_000F;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] dpon;
    logic [3:0] en;
  } ctrl_t;

endpackage

// File: rtl/mmio_sevenseg_hex_to_7seg.sv
// rtl/mmio_sevenseg_hex_to_7seg.sv - hex nibble to active-low {g,f,e,d,c,b,a} decoder
module hex_to_7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/mmio_sevenseg.sv
// rtl/mmio_sevenseg.sv - store-bus mapped four-digit seven-segment scan controller
module mmio_sevenseg
  import sevenseg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam logic [19:0] PCNT_TC = 20'(SCAN_DIV - 1);

  logic [15:0] data_q, data_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [19:0] pcnt_q, pcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [2:0]  ofs;
  logic [3:0]  nib;
  logic [6:0]  nib_seg;
  logic        dig_en;
  logic        dig_dp;
  logic        unused_bits;

  // Byte lanes are irrelevant: both registers are whole words.
  assign sel         = (memaddr[31:3] == BASE_ADDR[31:3]);
  assign ofs         = {memaddr[2], 2'b00};
  assign unused_bits = ^{memaddr[1:0], memwritedata[31:16]};

  always_comb begin
    memreaddata = 32'h0;
    if (sel) begin
      if (ofs == OFS_CTRL) memreaddata = {24'h0, ctrl_q};
      else                 memreaddata = {16'h0, data_q};
    end
  end

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (memwrite && sel) begin
      if (ofs == OFS_DATA) data_d = memwritedata[15:0];
      else                 ctrl_d = memwritedata[7:0];
    end
  end

  always_comb begin
    pcnt_d = pcnt_q + 20'd1;
    idx_d  = idx_q;
    if (pcnt_q >= PCNT_TC) begin
      pcnt_d = 20'd0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_comb begin
    nib    = data_q[3:0];
    dig_en = ctrl_q.en[0];
    dig_dp = ctrl_q.dpon[0];
    case (idx_q)
      2'd0: begin nib = data_q[3:0];   dig_en = ctrl_q.en[0]; dig_dp = ctrl_q.dpon[0]; end
      2'd1: begin nib = data_q[7:4];   dig_en = ctrl_q.en[1]; dig_dp = ctrl_q.dpon[1]; end
      2'd2: begin nib = data_q[11:8];  dig_en = ctrl_q.en[2]; dig_dp = ctrl_q.dpon[2]; end
      default: begin nib = data_q[15:12]; dig_en = ctrl_q.en[3]; dig_dp = ctrl_q.dpon[3]; end
    endcase
  end

  hex_to_7seg u_hex (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  // Pins are computed from the current registers and re-timed so each comes from a flop.
  always_comb begin
    an_d         = 4'b1111;
    an_d[idx_q]  = ~dig_en;
    seg_d        = dig_en ? nib_seg : SEG_BLANK;
    dp_d         = ~(dig_dp & dig_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= 16'h0;
      ctrl_q <= ctrl_t'(CTRL_RST[7:0]);
      pcnt_q <= 20'd0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_mmio_sevenseg.sv
// tb/tb_mmio_sevenseg.sv - scoreboard bench for mmio_sevenseg against a behavioural display model
module tb_mmio_sevenseg;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int SD = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        sel;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  mmio_sevenseg #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .sel          (sel),
    .seg          (seg),
    .dp           (dp),
    .an           (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    bit          rchk;
    logic        sel;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: register contents plus number of clock edges seen since reset release.
  logic [15:0] m_data;
  logic [7:0]  m_ctrl;
  int          k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd7);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_win(a)) return 32'h0;
    return (a - BASE >= 32'd4) ? {24'h0, m_ctrl} : {16'h0, m_data};
  endfunction

  task automatic cycle(input logic rn, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit rchk);
    exp_t e;
    int   dig;
    logic en_b;
    @(negedge clk);
    reset = rn; memwrite = w; memaddr = a; memwritedata = d;
    if (!rn) begin
      m_data = 16'h0; m_ctrl = 8'h0F; k = 0;
      e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    end else begin
      dig   = (k / SD) % 4;
      en_b  = m_ctrl[dig];
      e.an  = en_b ? (4'b1111 & ~(4'b0001 << dig)) : 4'b1111;
      e.seg = en_b ? hex_tab[(m_data >> (4 * dig)) & 16'hF] : 7'b1111111;
      e.dp  = !(en_b && m_ctrl[4 + dig]);
    end
    e.rchk = rchk && !w;
    e.sel  = in_win(a);
    e.rd   = model_read(a);
    q.push_back(e);
    if (rn) begin
      if (w && in_win(a)) begin
        if (a - BASE >= 32'd4) m_ctrl = d[7:0];
        else                   m_data = d[15:0];
      end
      k++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, BASE + 32'd16, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 5))
      4:       return BASE + 32'd8;
      5:       return $urandom;
      default: return BASE + 32'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", {28'h0, an}, {28'h0, e.an});
        chk("seg", {25'h0, seg}, {25'h0, e.seg});
        chk("dp", {31'h0, dp}, {31'h0, e.dp});
        chk("sel", {31'h0, sel}, {31'h0, e.sel});
        if (e.rchk) chk("readback", memreaddata, e.rd);
      end
    end
  end

  initial begin : driver
    reset = 1'b0; memwrite = 1'b0; memaddr = 32'h0; memwritedata = 32'h0;
    m_data = 16'h0; m_ctrl = 8'h0F; k = 0;

    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b0);
    cycle(1'b0, 1'b0, BASE, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, BASE + 32'd4, 32'h0, 1'b1);

    cycle(1'b1, 1'b1, BASE, 32'h0000_12AF, 1'b0);
    idle(20);

    cycle(1'b1, 1'b1, BASE + 32'd4, 32'h0000_002B, 1'b0);
    idle(18);
    cycle(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b1);

    cycle(1'b1, 1'b1, BASE + 32'd1, 32'hFFFF_ABCD, 1'b0);
    cycle(1'b1, 1'b0, BASE, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, BASE + 32'd8, 32'h1234_5678, 1'b0);
    cycle(1'b1, 1'b0, BASE + 32'd8, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, BASE, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, BASE + 32'd4, 32'h0, 1'b1);

    cycle(1'b1, 1'b1, BASE + 32'd4, 32'h0000_000F, 1'b0);
    while ((k % 16) != 10) idle(1);
    // Asynchronous reset between edges with idx=2, pcnt=2.
    #3;
    memwrite = 1'b0; memaddr = BASE; reset = 1'b0;
    #1;
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'h1);
    chk("rst_data", memreaddata, 32'h0);
    m_data = 16'h0; m_ctrl = 8'h0F; k = 0;
    cycle(1'b0, 1'b0, BASE, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, BASE, 32'h0, 1'b1);
    idle(3);

    for (int n = 0; n < 6; n++) begin
      while ((k % SD) != SD - 1) idle(1);
      cycle(1'b1, 1'b1, BASE + 32'(4 * (n % 2)), $urandom, 1'b0);
      idle(1);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b1, rnd_addr(), $urandom, 1'b0);
      else                           cycle(1'b1, 1'b0, rnd_addr(), 32'h0, 1'b1);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
